// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared types and widths for the UART transmit path       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : circular byte store with wrap pointers and count        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] c_ptr_one   = AW'(1);
    localparam logic [CW-1:0] c_count_one = CW'(1);
    localparam logic [CW-1:0] c_depth     = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    // Flush wins over a same-cycle push so a cleared FIFO stays empty.
    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o;

    assign full_o    = (r_count == c_depth);
    assign empty_o   = (r_count == '0);
    assign count_o   = r_count;
    assign rd_data_o = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO draining into the UART transmitter         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = UART_BYTE_W,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_valid_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    output logic                    push_ready_o,
    input  logic                    flush_i,
    output logic                    tx_start_o,
    output logic [DATA_WIDTH-1:0]   tx_data_o,
    input  logic                    tx_busy_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overflow_o,
    input  logic                    overflow_clr_i
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [TW-1:0] c_timeout_last = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] c_timeout_one  = TW'(1);

    tx_state_e             r_state;
    tx_state_e             w_state_next;
    logic [TW-1:0]         r_timeout_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [DATA_WIDTH-1:0] w_fifo_rd_data;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_timeout_hit;

    assign push_ready_o  = !full_o;
    assign w_push        = push_valid_i && push_ready_o;
    assign w_pop         = (r_state == IDLE) && !empty_o && !tx_busy_i;
    assign w_timeout_hit = (r_timeout_cnt == c_timeout_last);
    assign tx_data_o     = r_tx_data;
    assign overflow_o    = r_overflow;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i (push_data_i),
        .pop_i       (w_pop),
        .flush_i     (flush_i),
        .rd_data_o   (w_fifo_rd_data),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never asserts busy must not stall the drain.
                if (tx_busy_i) begin
                    w_state_next = WAIT_DONE;
                end else if (w_timeout_hit) begin
                    w_state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_start_o = (r_state == START);
    end

    // WAIT_BUSY is only ever entered from START, so clearing there restarts the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_timeout_cnt <= '0;
        end else if (r_state == START) begin
            r_timeout_cnt <= '0;
        end else if ((r_state == WAIT_BUSY) && !tx_busy_i) begin
            r_timeout_cnt <= r_timeout_cnt + c_timeout_one;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_data <= '0;
        end else if (w_pop) begin
            r_tx_data <= w_fifo_rd_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (overflow_clr_i) begin
            r_overflow <= 1'b0;
        end else if (push_valid_i && full_o) begin
            r_overflow <= 1'b1;
        end
    end

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed vectors and transmitter-model sequences  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_uart_tx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       push_valid_i;
    logic [7:0] push_data_i;
    logic       push_ready_o;
    logic       flush_i;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       tx_busy_i;
    logic [4:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       overflow_o;
    logic       overflow_clr_i;

    int checks   = 0;
    int failures = 0;

    // 0: busy from busy_drv, 1: transmitter model, 2: busy never asserted
    int   mode     = 0;
    logic busy_drv = 1'b0;
    int   mcnt     = 0;
    int   cyc      = 0;
    int   viol     = 0;
    logic [7:0] start_q [$];
    int         start_cyc [$];

    uart_tx_fifo #(
        .DEPTH        (16),
        .DATA_WIDTH   (8),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_valid_i   (push_valid_i),
        .push_data_i    (push_data_i),
        .push_ready_o   (push_ready_o),
        .flush_i        (flush_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .tx_busy_i      (tx_busy_i),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i)
    );

    always #5 clk_i = ~clk_i;

    assign tx_busy_i = (mode == 1) ? (mcnt != 0) : ((mode == 2) ? 1'b0 : busy_drv);

    // Transmitter model: busy rises the cycle after start and lasts 11 cycles.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcnt <= 0;
        end else if (tx_start_o) begin
            mcnt <= 11;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end
    end

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (tx_start_o) begin
            start_q.push_back(tx_data_o);
            start_cyc.push_back(cyc);
            if (mode == 1 && tx_busy_i) viol <= viol + 1;
        end
    end

    typedef struct packed {
        logic       pv;
        logic [7:0] pd;
        logic       fl;
        logic       busy;
        logic       oclr;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       rdy;
        logic       st;
        logic       ovf;
        logic [7:0] dat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        push_valid_i   = 1'b0;
        push_data_i    = 8'h00;
        flush_i        = 1'b0;
        overflow_clr_i = 1'b0;
        busy_drv       = 1'b0;
        mode           = 0;
        rst_ni         = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k = 0;
        while (start_q.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (start_q.size() < n) begin
            failures++;
            $display("FAIL %s: got %0d starts expected %0d within %0d cycles",
                     name, start_q.size(), n, budget);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        push_valid_i = 1'b1;
        push_data_i  = d;
        step();
        push_valid_i = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        logic rdy;

        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
        vecs[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[9]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[11] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h66};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h66};

        // Reset state
        rst_ni = 1'b0;
        push_valid_i = 1'b0; push_data_i = 8'h00; flush_i = 1'b0; overflow_clr_i = 1'b0;
        #12;
        chk("reset_state", {count_o, empty_o, full_o, push_ready_o, tx_start_o, overflow_o, tx_data_o},
            {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

        // Directed vector table, busy driven per row
        do_reset();
        for (int i = 0; i < 14; i++) begin
            push_valid_i   = vecs[i].pv;
            push_data_i    = vecs[i].pd;
            flush_i        = vecs[i].fl;
            busy_drv       = vecs[i].busy;
            overflow_clr_i = vecs[i].oclr;
            step();
            chk($sformatf("vec%0d", i),
                {count_o, empty_o, full_o, push_ready_o, tx_start_o, overflow_o, tx_data_o},
                {vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].rdy, vecs[i].st, vecs[i].ovf, vecs[i].dat});
        end
        push_valid_i = 1'b0; flush_i = 1'b0; overflow_clr_i = 1'b0;

        // Single byte with transmitter model: start two edges after accept
        do_reset();
        mode = 1;
        base = start_q.size();
        viol = 0;
        push_byte(8'h41);
        chk("single_count_after_accept", count_o, 5'd1);
        chk("single_no_start_yet", tx_start_o, 1'b0);
        step();
        chk("single_start_pulse", {tx_start_o, tx_data_o, count_o}, {1'b1, 8'h41, 5'd0});
        step();
        chk("single_start_one_cycle", tx_start_o, 1'b0);
        repeat (30) step();
        chk("single_start_count", start_q.size() - base, 1);
        chk("single_no_start_while_busy", viol, 0);
        chk("single_empty_after", {count_o, empty_o}, {5'd0, 1'b1});

        // Burst to full, overflow, then drain in order
        do_reset();
        busy_drv = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("burst_full", {full_o, push_ready_o, count_o}, {1'b1, 1'b0, 5'd16});
        push_byte(8'hAA);
        chk("burst_overflow", {overflow_o, count_o}, {1'b1, 5'd16});
        base = start_q.size();
        mode = 1;
        wait_starts(base + 16, 16 * 14 + 40, "burst_drain");
        repeat (40) step();
        chk("burst_drain_len", start_q.size() - base, 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < start_q.size())
                chk($sformatf("burst_byte%0d", i), start_q[base + i], 8'(i));
        end

        // Simultaneous push/pop at count 5, then 40-byte wrap scoreboard
        do_reset();
        busy_drv = 1'b1;
        base = start_q.size();
        for (int i = 0; i < 5; i++) push_byte(8'h80 + 8'(i));
        chk("pushpop_pre_count", count_o, 5'd5);
        busy_drv = 1'b0;
        push_byte(8'h85);
        chk("pushpop_count_same", {count_o, tx_start_o}, {5'd5, 1'b1});
        mode = 1;
        viol = 0;
        n = 6;
        for (int k = 0; k < 3000 && n < 40; k++) begin
            rdy = push_ready_o;
            push_valid_i = 1'b1;
            push_data_i  = 8'h80 + 8'(n);
            step();
            if (rdy) n++;
        end
        push_valid_i = 1'b0;
        wait_starts(base + 40, 1000, "wrap_drain");
        repeat (20) step();
        chk("wrap_len", start_q.size() - base, 40);
        chk("wrap_no_start_while_busy", viol, 0);
        for (int i = 0; i < 40; i++) begin
            if (base + i < start_q.size())
                chk($sformatf("wrap_byte%0d", i), start_q[base + i], 8'h80 + 8'(i));
        end

        // Transmitter never busy: timeout releases the FSM
        do_reset();
        mode = 2;
        base = start_q.size();
        push_byte(8'hC1);
        push_byte(8'hC2);
        chk("timeout_first", {count_o, tx_start_o, tx_data_o}, {5'd1, 1'b1, 8'hC1});
        wait_starts(base + 2, 40, "timeout_second");
        if (start_q.size() >= base + 2) begin
            chk("timeout_spacing", start_cyc[base + 1] - start_cyc[base], 17);
            chk("timeout_second_byte", start_q[base + 1], 8'hC2);
        end
        chk("timeout_count_zero", count_o, 5'd0);

        // Overflow clear priority, then flush during WAIT_DONE
        do_reset();
        busy_drv = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'hD0 + 8'(i));
        push_valid_i = 1'b1; push_data_i = 8'hEE; overflow_clr_i = 1'b1;
        step();
        chk("ovf_clr_priority", overflow_o, 1'b0);
        overflow_clr_i = 1'b0;
        step();
        chk("ovf_set", overflow_o, 1'b1);
        push_valid_i = 1'b0; overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        chk("ovf_clear", {overflow_o, count_o}, {1'b0, 5'd16});
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_full", {count_o, empty_o, push_ready_o}, {5'd0, 1'b1, 1'b1});
        for (int i = 0; i < 8; i++) push_byte(8'h70 + 8'(i));
        busy_drv = 1'b0;
        step();
        busy_drv = 1'b1;
        step();
        step();
        chk("flush_pre_count", {count_o, tx_data_o}, {5'd7, 8'h70});
        base = start_q.size();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_count_zero", {count_o, empty_o}, {5'd0, 1'b1});
        busy_drv = 1'b0;
        repeat (30) step();
        chk("flush_no_more_starts", start_q.size() - base, 0);
        chk("flush_inflight_held", tx_data_o, 8'h70);

        // Asynchronous reset in WAIT_DONE
        do_reset();
        push_byte(8'h99);
        push_byte(8'h9A);
        busy_drv = 1'b1;
        push_byte(8'h9B);
        step();
        chk("areset_pre", {count_o, tx_data_o}, {5'd2, 8'h99});
        #2;
        rst_ni = 1'b0;
        #1;
        chk("areset_immediate", {count_o, empty_o, full_o, push_ready_o, tx_start_o, overflow_o, tx_data_o},
            {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        mode = 1;
        viol = 0;
        base = start_q.size();
        push_byte(8'h55);
        wait_starts(base + 1, 20, "areset_resume");
        repeat (30) step();
        chk("areset_one_start", start_q.size() - base, 1);
        if (start_q.size() > base) chk("areset_byte", start_q[base], 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_fifo
`default_nettype wire
